// File: rtl/ula_sequencer.sv
// Operand-entry and execution sequencer for the 8-bit ULA datapath.
// Conditions the enter/reuso buttons into single-cycle pulses, loads operand A,
// operand B and the opcode from the switches, then captures the ULA result.
module ula_sequencer #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3,
  parameter int FLAGW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enter,
  input  logic             reuso,
  input  logic [WIDTH-1:0] sw,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [FLAGW-1:0] alu_flags,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [OPW-1:0]   op_sel,
  output logic [WIDTH-1:0] result_q,
  output logic [FLAGW-1:0] flags_q,
  output logic             result_valid,
  output logic             done,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_A    = 3'b000,
    S_B    = 3'b001,
    S_OP   = 3'b010,
    S_EXEC = 3'b011,
    S_SHOW = 3'b100
  } state_t;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_d, b_d, res_d;
  logic [OPW-1:0]   sel_d;
  logic [FLAGW-1:0] flg_d;
  logic             valid_d, done_d;

  // Synchronizer and edge-delay flops; reset high so a button held through
  // reset must be released and pressed again before it produces a pulse.
  logic e_s0, e_s1, e_d;
  logic r_s0, r_s1, r_d;
  logic enter_pulse, reuso_pulse;

  // Two-flop synchronizers plus delay flop for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {e_s0, e_s1, e_d} <= 3'b111;
      {r_s0, r_s1, r_d} <= 3'b111;
    end else begin
      e_s0 <= enter;
      e_s1 <= e_s0;
      e_d  <= e_s1;
      r_s0 <= reuso;
      r_s1 <= r_s0;
      r_d  <= r_s1;
    end
  end

  assign enter_pulse = e_s1 & ~e_d;
  assign reuso_pulse = r_s1 & ~r_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_A;
      op_a         <= '0;
      op_b         <= '0;
      op_sel       <= '0;
      result_q     <= '0;
      flags_q      <= '0;
      result_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_a         <= a_d;
      op_b         <= b_d;
      op_sel       <= sel_d;
      result_q     <= res_d;
      flags_q      <= flg_d;
      result_valid <= valid_d;
      done         <= done_d;
    end
  end

  // Next-state and register-load decisions; everything holds unless a state loads it
  always_comb begin
    state_d = state_q;
    a_d     = op_a;
    b_d     = op_b;
    sel_d   = op_sel;
    res_d   = result_q;
    flg_d   = flags_q;
    valid_d = result_valid;
    done_d  = 1'b0;
    case (state_q)
      S_A: begin
        // Reusing the last result wins over a fresh switch entry
        if (reuso_pulse && result_valid) begin
          a_d     = result_q;
          state_d = S_B;
        end else if (enter_pulse) begin
          a_d     = sw;
          state_d = S_B;
        end
      end
      S_B: begin
        if (enter_pulse) begin
          b_d     = sw;
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (enter_pulse) begin
          sel_d   = sw[OPW-1:0];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d   = alu_result;
        flg_d   = alu_flags;
        valid_d = 1'b1;
        done_d  = 1'b1;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        // Chain the shown result into operand A, or return to fresh entry
        if (reuso_pulse) begin
          a_d     = result_q;
          state_d = S_B;
        end else if (enter_pulse) begin
          state_d = S_A;
        end
      end
      default: state_d = S_A;
    endcase
  end

  assign state = state_q;

endmodule
